pause_sequencer: RTL and testbench

// - Arbitrates all CPU-pause requesters (player pause button, OSD open, hiscore engine) into one pause_cpu

---
 rtl/pause_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pause_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pause_sequencer.sv
// -----------------------------------------------------------------------------
// pause_sequencer
//
// Purpose:
//   Merges every CPU-pause requester (player pause button, OSD, hiscore engine)
//   into one pause_cpu strobe for the game core. Pause entry is aligned to the
//   rising edge of vertical blank so the game never freezes mid-frame. If no
//   vblank edge arrives, entry is forced after a timeout. The block also
//   acknowledges the hiscore engine once the CPU is halted, and raises a
//   dim-after-idle video flag.
//
// Build option:
//   PAUSE_SEQ_DEBOUNCE_EN - when defined, the synchronised user_button level
//   must stay stable for 2^16 consecutive clocks before it is accepted.
//
// Ports:
//   clk          in   system clock (clk_sys)
//   reset        in   synchronous, active-high reset
//   user_button  in   player pause button, level, asynchronous to clk
//   osd_open     in   OSD visible
//   hs_pause_req in   hiscore engine requests CPU halt, level
//   vblank       in   vertical blank, level, already in clk domain
//   options[1:0] in   [0] pause when OSD open, [1] dim enable
//   pause_cpu    out  halt game CPU (registered, high exactly while PAUSED)
//   hs_paused    out  hiscore ack: CPU halted and hs_pause_req active
//   dim_video    out  halve RGB intensity
// -----------------------------------------------------------------------------
module pause_sequencer #(
  parameter int unsigned CLKS_PER_SEC = 30_000_000,
  parameter int unsigned DIM_SECS     = 10,
  parameter int unsigned VBL_TIMEOUT  = 600_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       user_button,
  input  logic       osd_open,
  input  logic       hs_pause_req,
  input  logic       vblank,
  input  logic [1:0] options,
  output logic       pause_cpu,
  output logic       hs_paused,
  output logic       dim_video
);

  localparam int unsigned DIM_LIMIT = CLKS_PER_SEC * DIM_SECS;
  localparam int DIM_W = $clog2(DIM_LIMIT + 1);
  localparam int TMO_W = $clog2(VBL_TIMEOUT + 1);
  localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(DIM_LIMIT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VBL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_VBL = 2'd1,
    ST_PAUSED   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             btn_meta_r;
  logic             btn_sync_r;
  logic             btn_level_s;
  logic             btn_prev_r;
  logic             btn_rise_s;
  logic             user_latch_r;
  logic             vblank_q_r;
  logic             vbl_rise_s;
  logic             req_s;
  logic [TMO_W-1:0] tmo_r;
  logic [DIM_W-1:0] dim_cnt_r;
  logic             pause_cpu_r;
  logic             hs_paused_r;
  logic             dim_video_r;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= user_button;
      btn_sync_r <= btn_meta_r;
    end
  end

`ifdef PAUSE_SEQ_DEBOUNCE_EN
  logic [15:0] db_cnt_r;
  logic        btn_stable_r;

  // Accept a new button level only after it has differed from the accepted
  // level for 65536 consecutive clocks; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_r     <= 16'd0;
      btn_stable_r <= 1'b0;
    end else if (btn_sync_r == btn_stable_r) begin
      db_cnt_r     <= 16'd0;
    end else if (db_cnt_r == 16'hFFFF) begin
      db_cnt_r     <= 16'd0;
      btn_stable_r <= btn_sync_r;
    end else begin
      db_cnt_r     <= db_cnt_r + 16'd1;
    end
  end

  assign btn_level_s = btn_stable_r;
`else
  assign btn_level_s = btn_sync_r;
`endif

  assign btn_rise_s = btn_level_s & ~btn_prev_r;
  assign vbl_rise_s = vblank & ~vblank_q_r;
  assign req_s      = user_latch_r | (osd_open & options[0]) | hs_pause_req;

  // Edge-detect history, button toggle latch and vblank history.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_r   <= 1'b0;
      user_latch_r <= 1'b0;
      vblank_q_r   <= 1'b0;
    end else begin
      btn_prev_r   <= btn_level_s;
      user_latch_r <= user_latch_r ^ btn_rise_s;
      vblank_q_r   <= vblank;
    end
  end

  // Next-state logic; a withdrawn request beats a simultaneous vblank edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (req_s) state_next_s = ST_WAIT_VBL;
        else       state_next_s = ST_RUN;
      end
      ST_WAIT_VBL: begin
        if (!req_s)                                  state_next_s = ST_RUN;
        else if (vbl_rise_s || (tmo_r == TMO_LAST))  state_next_s = ST_PAUSED;
        else                                         state_next_s = ST_WAIT_VBL;
      end
      ST_PAUSED: begin
        if (!req_s) state_next_s = ST_RUN;
        else        state_next_s = ST_PAUSED;
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_RUN;
    else       state_r <= state_next_s;
  end

  // Vblank timeout: held at zero in RUN so it starts fresh on WAIT_VBL entry,
  // and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)                                             tmo_r <= '0;
    else if (state_r == ST_RUN)                            tmo_r <= '0;
    else if ((state_r == ST_WAIT_VBL) && (tmo_r != TMO_LAST)) tmo_r <= tmo_r + 1'b1;
    else                                                   tmo_r <= tmo_r;
  end

  // Idle counter for dimming: runs only while PAUSED, restarts on any press.
  always_ff @(posedge clk) begin
    if (reset)                                 dim_cnt_r <= '0;
    else if ((state_r != ST_PAUSED) || btn_rise_s) dim_cnt_r <= '0;
    else if (dim_cnt_r != DIM_MAX)             dim_cnt_r <= dim_cnt_r + 1'b1;
    else                                       dim_cnt_r <= dim_cnt_r;
  end

  // Registered outputs; pause_cpu follows the state register exactly.
  // A hiscore-only pause never dims because neither latch nor OSD is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_cpu_r <= 1'b0;
      hs_paused_r <= 1'b0;
      dim_video_r <= 1'b0;
    end else begin
      pause_cpu_r <= (state_next_s == ST_PAUSED);
      hs_paused_r <= (state_next_s == ST_PAUSED) & hs_pause_req;
      dim_video_r <= (dim_cnt_r == DIM_MAX) & options[1] & (user_latch_r | osd_open);
    end
  end

  assign pause_cpu = pause_cpu_r;
  assign hs_paused = hs_paused_r;
  assign dim_video = dim_video_r;

endmodule

// File: tb/tb_pause_sequencer.sv
module tb_pause_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       user_button = 1'b0;
  logic       osd_open = 1'b0;
  logic       hs_pause_req = 1'b0;
  logic       vblank = 1'b0;
  logic [1:0] options = 2'b00;
  logic       pause_cpu;
  logic       hs_paused;
  logic       dim_video;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pause_sequencer #(
    .CLKS_PER_SEC(100),
    .DIM_SECS    (2),
    .VBL_TIMEOUT (50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .user_button (user_button),
    .osd_open    (osd_open),
    .hs_pause_req(hs_pause_req),
    .vblank      (vblank),
    .options     (options),
    .pause_cpu   (pause_cpu),
    .hs_paused   (hs_paused),
    .dim_video   (dim_video)
  );

  // One clocked vector: inputs, then expected {pause_cpu, hs_paused, dim_video}
  // right after the edge that samples those inputs.
  typedef struct packed {
    logic       rst;
    logic       btn;
    logic       osd;
    logic       hs;
    logic       vbl;
    logic [1:0] opt;
    logic [2:0] exp;
  } vec_t;

  vec_t vec [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    user_button  = 1'b0;
    osd_open     = 1'b0;
    hs_pause_req = 1'b0;
    vblank       = 1'b0;
    options      = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int cnt;
    logic seen;

    //          rst   btn   osd   hs    vbl   opt    exp{p,h,d}
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000}; // reset
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000}; // hs req -> WAIT
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b110}; // vbl rise -> PAUSED
    vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b110};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b110};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000}; // hs drop -> both 0
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000}; // osd w/o enable: no req
    vec[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000}; // osd req -> WAIT
    vec[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b100}; // paused, no hs ack
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 3'b110}; // hs joins -> ack
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b110};
    vec[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b110};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000}; // all drop -> RUN
    vec[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000}; // -> WAIT
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000}; // withdraw beats vbl rise
    vec[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000}; // vbl high, no edge
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000};
    vec[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b110}; // rise -> PAUSED
    vec[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000}; // reset from PAUSED
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};

    clear_inputs();
    #1;
    for (int i = 0; i < 21; i++) begin
      reset        = vec[i].rst;
      user_button  = vec[i].btn;
      osd_open     = vec[i].osd;
      hs_pause_req = vec[i].hs;
      vblank       = vec[i].vbl;
      options      = vec[i].opt;
      step(1);
      check($sformatf("vec%0d", i), {29'd0, pause_cpu, hs_paused, dim_video}, {29'd0, vec[i].exp});
    end

    // Forced entry by timeout with vblank held low: one edge to register the
    // request, then 50 cycles in WAIT_VBL.
    do_reset();
    osd_open = 1'b1;
    options  = 2'b11;
    step(1);
    cnt = 1;
    while ((pause_cpu !== 1'b1) && (cnt < 200)) begin
      step(1);
      cnt++;
    end
    check("timeout_entry_edges", cnt, 51);
    step(200);
    check("dim_before_limit", dim_video, 1'b0);
    step(1);
    check("dim_at_limit", dim_video, 1'b1);
    options = 2'b01;
    step(1);
    check("dim_disable", dim_video, 1'b0);
    check("pause_held_osd", pause_cpu, 1'b1);
    osd_open = 1'b0;
    step(1);
    check("osd_close_resume", pause_cpu, 1'b0);

    // Hiscore-only pause never dims; OSD without pause enable still makes it
    // dim-eligible.
    do_reset();
    hs_pause_req = 1'b1;
    options      = 2'b11;
    step(2);
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    check("hs_pause_entry", {hs_paused, pause_cpu}, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      seen = seen | dim_video;
    end
    check("hs_only_no_dim", seen, 1'b0);
    osd_open = 1'b1;
    options  = 2'b10;
    step(1);
    check("osd_dim_eligible", {pause_cpu, dim_video}, 2'b11);
    hs_pause_req = 1'b0;
    step(1);
    check("hs_drop_resume", {pause_cpu, hs_paused}, 2'b00);

`ifndef PAUSE_SEQ_DEBOUNCE_EN
    // Button pause: enter at vblank, dim, then second press resumes.
    do_reset();
    options     = 2'b10;
    user_button = 1'b1;
    step(2);
    user_button = 1'b0;
    step(4);
    check("btn_wait_vbl", pause_cpu, 1'b0);
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    check("btn_pause_entry", pause_cpu, 1'b1);
    step(205);
    check("btn_dim", dim_video, 1'b1);
    user_button = 1'b1;
    step(2);
    check("btn2_b2_paused", pause_cpu, 1'b1);
    user_button = 1'b0;
    step(1);
    check("btn2_b3_paused", pause_cpu, 1'b1);
    step(1);
    check("btn2_b4_resume", {pause_cpu, dim_video}, 2'b00);

    // Reset while paused clears outputs and the button latch.
    do_reset();
    user_button = 1'b1;
    step(2);
    user_button = 1'b0;
    step(4);
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    check("pre_reset_paused", pause_cpu, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_outputs", {pause_cpu, hs_paused, dim_video}, 3'b000);
    step(3);
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    step(60);
    check("latch_cleared", pause_cpu, 1'b0);
`else
    // Debounce: a short glitch is ignored, a long press toggles exactly once.
    do_reset();
    user_button = 1'b1;
    step(1000);
    user_button = 1'b0;
    step(200);
    check("db_glitch_ignored", pause_cpu, 1'b0);
    user_button = 1'b1;
    step(70000);
    check("db_press_toggle", pause_cpu, 1'b1);
    user_button = 1'b0;
    step(1000);
    check("db_single_toggle", pause_cpu, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
